// File: rtl/aim_pkg.sv
// Shared defaults and FSM encoding for the AIM spike monitor.
// Detector states: IDLE = armed with no prior spike, REFRACT = just fired, ARMED = re-armed after a spike.
package aim_pkg;
    localparam int                 AIM_DATA_W     = 16;
    localparam logic signed [15:0] AIM_THRESH     = 16'sd30;
    localparam logic signed [15:0] AIM_REARM      = 16'sd0;
    localparam int                 AIM_ISI_W      = 16;
    localparam int                 AIM_CNT_W      = 16;
    localparam int                 AIM_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REFRACT = 2'd1,
        ST_ARMED   = 2'd2
    } aim_state_t;
endpackage

// File: rtl/aim_isi_fifo.sv
// Synchronous show-ahead FIFO for inter-spike intervals; head is zero while empty.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module aim_isi_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push_eff;
    logic          w_pop_eff;

    assign full       = (r_cnt == (AW+1)'(DEPTH));
    assign empty      = (r_cnt == '0);
    assign w_pop_eff  = pop & ~empty;
    assign w_push_eff = push & (~full | w_pop_eff);
    assign dout       = empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (clear) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push_eff) r_wr <= r_wr + 1'b1;
            if (w_pop_eff)  r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push_eff) - (AW+1)'(w_pop_eff);
        end
    end

    // Storage needs no reset: dout is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push_eff && !clear) r_mem[r_wr] <= din;
    end
endmodule

// File: rtl/aim_spike_monitor.sv
// Turns the AIM membrane-potential stream into spike pulses with re-arm hysteresis,
// a saturating spike count, and a FIFO of inter-spike intervals (valid/ready reader side).
module aim_spike_monitor
    import aim_pkg::*;
#(
    parameter int                        DATA_W     = AIM_DATA_W,
    parameter logic signed [DATA_W-1:0]  THRESH     = DATA_W'(AIM_THRESH),
    parameter logic signed [DATA_W-1:0]  REARM      = DATA_W'(AIM_REARM),
    parameter int                        ISI_W      = AIM_ISI_W,
    parameter int                        CNT_W      = AIM_CNT_W,
    parameter int                        FIFO_DEPTH = AIM_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_neuron,
    input  logic                     enable,
    input  logic                     clear_stats,
    output logic                     spike,
    output logic [CNT_W-1:0]         spike_count,
    output logic [ISI_W-1:0]         isi_data,
    output logic                     isi_valid,
    input  logic                     isi_ready,
    output logic                     overflow,
    output aim_state_t               dbg_state
);
    // Reader handshake: isi_data is the FIFO head while isi_valid is high; the head
    // is consumed on any rising edge where isi_valid & isi_ready are both high.
    aim_state_t       r_state;
    aim_state_t       w_state_nxt;
    logic             w_accept;
    logic             w_fire;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [ISI_W-1:0] r_isi;
    logic [ISI_W-1:0] w_isi_push_val;
    logic [CNT_W-1:0] r_count;
    logic             r_spike;
    logic             r_overflow;

    assign w_accept = in_valid & enable;

    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        w_push      = 1'b0;
        if (w_accept && !clear_stats) begin
            case (r_state)
                ST_IDLE: begin
                    if (in_neuron >= THRESH) begin
                        w_fire      = 1'b1;
                        w_state_nxt = ST_REFRACT;
                    end
                end
                ST_REFRACT: begin
                    if (in_neuron < REARM) w_state_nxt = ST_ARMED;
                end
                ST_ARMED: begin
                    if (in_neuron >= THRESH) begin
                        w_fire      = 1'b1;
                        w_push      = 1'b1;
                        w_state_nxt = ST_REFRACT;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // The firing sample itself completes the interval, hence counter + 1.
    assign w_isi_push_val = (r_isi == '1) ? r_isi : r_isi + 1'b1;
    assign w_pop          = ~w_empty & isi_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_isi      <= '0;
            r_count    <= '0;
            r_spike    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (clear_stats) begin
            r_state    <= ST_IDLE;
            r_isi      <= '0;
            r_count    <= '0;
            r_spike    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_spike <= w_fire;
            if (w_fire) begin
                r_isi <= '0;
            end else if (w_accept && (r_state != ST_IDLE) && (r_isi != '1)) begin
                r_isi <= r_isi + 1'b1;
            end
            if (w_fire && (r_count != '1)) r_count <= r_count + 1'b1;
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    aim_isi_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ISI_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_stats),
        .push  (w_push),
        .din   (w_isi_push_val),
        .pop   (w_pop),
        .dout  (isi_data),
        .full  (w_full),
        .empty (w_empty)
    );

    assign isi_valid   = ~w_empty;
    assign spike       = r_spike;
    assign spike_count = r_count;
    assign overflow    = r_overflow;
    assign dbg_state   = r_state;
endmodule

// File: tb/tb_aim_spike_monitor.sv
// Directed bench for aim_spike_monitor: a default instance plus an ISI_W=4 instance on shared stimulus.
module tb_aim_spike_monitor;
    import aim_pkg::*;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic signed [15:0] in_neuron;
    logic               enable;
    logic               clear_stats;
    logic               isi_ready;
    logic               spike;
    logic [15:0]        spike_count;
    logic [15:0]        isi_data;
    logic               isi_valid;
    logic               overflow;
    aim_state_t         dbg_state;
    logic               spike4;
    logic [15:0]        spike_count4;
    logic [3:0]         isi_data4;
    logic               isi_valid4;
    logic               overflow4;
    aim_state_t         dbg_state4;

    int n_cmp = 0;
    int n_err = 0;
    int n_spk = 0;

    aim_spike_monitor u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_neuron(in_neuron),
        .enable(enable), .clear_stats(clear_stats), .spike(spike),
        .spike_count(spike_count), .isi_data(isi_data), .isi_valid(isi_valid),
        .isi_ready(isi_ready), .overflow(overflow), .dbg_state(dbg_state)
    );

    aim_spike_monitor #(.ISI_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_neuron(in_neuron),
        .enable(enable), .clear_stats(clear_stats), .spike(spike4),
        .spike_count(spike_count4), .isi_data(isi_data4), .isi_valid(isi_valid4),
        .isi_ready(isi_ready), .overflow(overflow4), .dbg_state(dbg_state4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic samp(input logic signed [15:0] v);
        in_valid  = 1'b1;
        in_neuron = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (spike === 1'b1) n_spk++;
    endtask

    task automatic idle_cyc();
        @(posedge clk);
        #1;
        if (spike === 1'b1) n_spk++;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (spike !== 1'b0) begin n_err++; $display("FAIL rst_spike: got %0d want 0", spike); end
        n_cmp++; if (spike_count !== 16'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", spike_count); end
        n_cmp++; if (isi_valid !== 1'b0 || isi_data !== 16'd0) begin n_err++; $display("FAIL rst_isi: got v=%0d d=%0d want 0/0", isi_valid, isi_data); end
        n_cmp++; if (overflow !== 1'b0 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rst_ovf_state: got ovf=%0d st=%0d want 0/0", overflow, dbg_state); end
        @(negedge clk);
        rst = 1'b0;
        idle_cyc();
    endtask

    task automatic test_first_spike();
        for (int i = 0; i < 9; i++) samp(-16'sd65);
        n_cmp++; if (spike !== 1'b0 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL pre_spike: got spk=%0d st=%0d want 0/IDLE", spike, dbg_state); end
        samp(16'sd35);
        n_cmp++; if (spike !== 1'b1) begin n_err++; $display("FAIL first_spike: got %0d want 1", spike); end
        n_cmp++; if (spike_count !== 16'd1) begin n_err++; $display("FAIL first_count: got %0d want 1", spike_count); end
        n_cmp++; if (isi_valid !== 1'b0) begin n_err++; $display("FAIL first_no_isi: got %0d want 0", isi_valid); end
    endtask

    task automatic test_isi();
        samp(16'sd5);
        n_cmp++; if (spike !== 1'b0) begin n_err++; $display("FAIL spike_pulse_width: got %0d want 0", spike); end
        samp(16'sd5);
        samp(-16'sd70);
        n_cmp++; if (dbg_state !== ST_ARMED) begin n_err++; $display("FAIL rearm_state: got %0d want %0d", dbg_state, ST_ARMED); end
        for (int i = 13; i < 24; i++) samp(-16'sd65);
        samp(16'sd35);
        n_cmp++; if (spike !== 1'b1 || spike_count !== 16'd2) begin n_err++; $display("FAIL second_spike: got spk=%0d cnt=%0d want 1/2", spike, spike_count); end
        n_cmp++; if (isi_valid !== 1'b1 || isi_data !== 16'd15) begin n_err++; $display("FAIL isi_15: got v=%0d d=%0d want 1/15", isi_valid, isi_data); end
        isi_ready = 1'b1;
        idle_cyc();
        isi_ready = 1'b0;
        n_cmp++; if (isi_valid !== 1'b0 || isi_data !== 16'd0) begin n_err++; $display("FAIL isi_pop: got v=%0d d=%0d want 0/0", isi_valid, isi_data); end
    endtask

    task automatic test_hold();
        int s0;
        s0 = n_spk;
        samp(-16'sd10);
        for (int i = 0; i < 6; i++) samp(16'sd35);
        samp(16'sd10);
        samp(16'sd35);
        n_cmp++; if (n_spk - s0 !== 1) begin n_err++; $display("FAIL hold_one_spike: got %0d want 1", n_spk - s0); end
        n_cmp++; if (spike_count !== 16'd3) begin n_err++; $display("FAIL hold_count: got %0d want 3", spike_count); end
        n_cmp++; if (isi_valid !== 1'b1 || isi_data !== 16'd2) begin n_err++; $display("FAIL hold_isi: got v=%0d d=%0d want 1/2", isi_valid, isi_data); end
        isi_ready = 1'b1;
        idle_cyc();
        isi_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [15:0] exp_d [4];
        clear_stats = 1'b1;
        samp(16'sd35);
        clear_stats = 1'b0;
        n_cmp++; if (spike !== 1'b0 || spike_count !== 16'd0 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL clear_priority: got spk=%0d cnt=%0d st=%0d want 0/0/IDLE", spike, spike_count, dbg_state); end
        n_cmp++; if (isi_valid !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL clear_fifo: got v=%0d ovf=%0d want 0/0", isi_valid, overflow); end
        samp(16'sd35);
        for (int n = 1; n <= 4; n++) begin
            for (int k = 0; k < n; k++) samp(-16'sd5);
            samp(16'sd35);
        end
        n_cmp++; if (overflow !== 1'b0 || isi_data !== 16'd2) begin n_err++; $display("FAIL fill4: got ovf=%0d d=%0d want 0/2", overflow, isi_data); end
        for (int k = 0; k < 5; k++) samp(-16'sd5);
        isi_ready = 1'b1;
        samp(16'sd35);
        isi_ready = 1'b0;
        n_cmp++; if (overflow !== 1'b0 || isi_data !== 16'd3) begin n_err++; $display("FAIL full_push_pop: got ovf=%0d d=%0d want 0/3", overflow, isi_data); end
        for (int k = 0; k < 6; k++) samp(-16'sd5);
        samp(16'sd35);
        n_cmp++; if (overflow !== 1'b1 || spike_count !== 16'd7) begin n_err++; $display("FAIL overflow_set: got ovf=%0d cnt=%0d want 1/7", overflow, spike_count); end
        exp_d[0] = 16'd3; exp_d[1] = 16'd4; exp_d[2] = 16'd5; exp_d[3] = 16'd6;
        isi_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (isi_valid !== 1'b1 || isi_data !== exp_d[i]) begin n_err++; $display("FAIL drain_%0d: got v=%0d d=%0d want 1/%0d", i, isi_valid, isi_data, exp_d[i]); end
            idle_cyc();
        end
        idle_cyc();
        isi_ready = 1'b0;
        n_cmp++; if (isi_valid !== 1'b0 || isi_data !== 16'd0 || overflow !== 1'b1) begin n_err++; $display("FAIL drain_empty: got v=%0d d=%0d ovf=%0d want 0/0/1", isi_valid, isi_data, overflow); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            samp(-16'sd5);
            samp(16'sd35);
        end
        n_cmp++; if (isi_valid !== 1'b1 || spike_count !== 16'd10 || spike !== 1'b1) begin n_err++; $display("FAIL pre_rst_burst: got v=%0d cnt=%0d spk=%0d want 1/10/1", isi_valid, spike_count, spike); end
        rst = 1'b1;
        #2;
        n_cmp++; if (spike !== 1'b0 || spike_count !== 16'd0 || overflow !== 1'b0) begin n_err++; $display("FAIL async_rst: got spk=%0d cnt=%0d ovf=%0d want 0/0/0", spike, spike_count, overflow); end
        n_cmp++; if (isi_valid !== 1'b0 || isi_data !== 16'd0 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL async_rst_fifo: got v=%0d d=%0d st=%0d want 0/0/IDLE", isi_valid, isi_data, dbg_state); end
        @(negedge clk);
        rst = 1'b0;
        samp(16'sd35);
        n_cmp++; if (spike !== 1'b1 || spike_count !== 16'd1 || isi_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_spike: got spk=%0d cnt=%0d v=%0d want 1/1/0", spike, spike_count, isi_valid); end
    endtask

    task automatic test_sat_enable();
        int s0;
        clear_stats = 1'b1;
        idle_cyc();
        clear_stats = 1'b0;
        samp(16'sd35);
        for (int i = 0; i < 19; i++) samp(-16'sd5);
        samp(16'sd35);
        n_cmp++; if (isi_data !== 16'd20) begin n_err++; $display("FAIL isi_20_w16: got %0d want 20", isi_data); end
        n_cmp++; if (isi_valid4 !== 1'b1 || isi_data4 !== 4'd15) begin n_err++; $display("FAIL isi_sat_w4: got v=%0d d=%0d want 1/15", isi_valid4, isi_data4); end
        isi_ready = 1'b1;
        idle_cyc();
        isi_ready = 1'b0;
        for (int i = 0; i < 4; i++) samp(-16'sd5);
        s0 = n_spk;
        enable = 1'b0;
        for (int i = 0; i < 10; i++) samp(16'sd35);
        enable = 1'b1;
        n_cmp++; if (n_spk !== s0 || dbg_state !== ST_ARMED) begin n_err++; $display("FAIL enable_hold: got spikes=%0d st=%0d want 0/ARMED", n_spk - s0, dbg_state); end
        for (int i = 0; i < 4; i++) samp(-16'sd5);
        samp(16'sd35);
        n_cmp++; if (isi_data !== 16'd9 || isi_data4 !== 4'd9) begin n_err++; $display("FAIL isi_gap: got w16=%0d w4=%0d want 9/9", isi_data, isi_data4); end
        n_cmp++; if (spike_count !== 16'd3 || spike_count4 !== 16'd3) begin n_err++; $display("FAIL gap_count: got %0d/%0d want 3/3", spike_count, spike_count4); end
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_neuron   = '0;
        enable      = 1'b1;
        clear_stats = 1'b0;
        isi_ready   = 1'b0;
        test_reset();
        test_first_spike();
        test_isi();
        test_hold();
        test_overflow();
        test_reset_mid();
        test_sat_enable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
